// File: rtl/fft_peak_sink_if.sv
// Handshake bundle between an FFT output stream and the peak sink.
// Carries the beat stream inbound and the single-result report outbound.
interface fft_peak_sink_if #(
    parameter int N_POINTS = 1024,
    parameter int DW       = 10
);
    localparam int BW = $clog2(N_POINTS);

    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_error;
    logic                 in_sop;
    logic                 in_eop;
    logic signed [DW-1:0] in_real;
    logic signed [DW-1:0] in_imag;
    logic signed [5:0]    in_exp;
    logic                 out_valid;
    logic                 out_ready;
    logic [BW-1:0]        peak_bin;
    logic [2*DW-1:0]      peak_pwr;
    logic [5:0]           peak_exp;
    logic                 frame_err;

    modport master (
        output in_valid, in_error, in_sop, in_eop,
        output in_real, in_imag, in_exp, out_ready,
        input  in_ready, out_valid, peak_bin,
        input  peak_pwr, peak_exp, frame_err
    );

    modport slave (
        input  in_valid, in_error, in_sop, in_eop,
        input  in_real, in_imag, in_exp, out_ready,
        output in_ready, out_valid, peak_bin,
        output peak_pwr, peak_exp, frame_err
    );
endinterface

// File: rtl/fft_peak_sink.sv
// Finds the max-power bin of each FFT frame and reports it once per frame.
// Optional FFT_PEAK_SKIP_DC_EN limits the search to bins 1..N_POINTS/2-1.
module fft_peak_sink #(
    parameter int N_POINTS = 1024,
    parameter int DW       = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    fft_peak_sink_if.slave bus
);
    localparam int BW = $clog2(N_POINTS);
    localparam int PW = 2 * DW;
    localparam logic [BW-1:0] LAST = BW'(N_POINTS - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

    state_t          state;
    logic [BW-1:0]   cnt;

    logic            s1_v;
    logic            s1_first;
    logic            s1_last;
    logic            s1_bad;
    logic            s1_cand;
    logic [BW-1:0]   s1_bin;
    logic [PW-1:0]   s1_pwr;
    logic [5:0]      s1_exp;

    logic            run_have;
    logic            run_err;
    logic [BW-1:0]   run_bin;
    logic [PW-1:0]   run_pwr;
    logic [5:0]      run_exp;
    logic            fin;

    logic                 counted;
    logic [BW-1:0]        bin;
    logic                 last;
    logic                 bad_end;
    logic                 cand;
    logic signed [PW-1:0] sq_r;
    logic signed [PW-1:0] sq_i;
    logic [PW-1:0]        pwr;
    logic                 base_have;
    logic                 base_err;
    logic                 take;
    logic                 consume;

    assign counted = bus.in_valid && bus.in_ready
                  && (state == COLLECT || bus.in_sop);
    assign bin     = bus.in_sop ? '0 : cnt;
    assign last    = bus.in_eop || (bin == LAST);
    // Early eop and a missing eop on the final bin are both malformed.
    assign bad_end = bus.in_eop != (bin == LAST);
    assign sq_r    = bus.in_real * bus.in_real;
    assign sq_i    = bus.in_imag * bus.in_imag;
    assign pwr     = $unsigned(sq_r) + $unsigned(sq_i);
    assign consume = bus.out_valid && bus.out_ready;

`ifdef FFT_PEAK_SKIP_DC_EN
    assign cand = (bin != '0) && (bin < BW'(N_POINTS / 2));
`else
    assign cand = 1'b1;
`endif

    // A frame start wipes the running peak before the compare.
    always_comb begin
        base_have = run_have;
        base_err  = run_err;
        if (s1_first) begin
            base_have = 1'b0;
            base_err  = 1'b0;
        end
        take = s1_cand && (!base_have || (s1_pwr > run_pwr));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            s1_v          <= 1'b0;
            s1_first      <= 1'b0;
            s1_last       <= 1'b0;
            s1_bad        <= 1'b0;
            s1_cand       <= 1'b0;
            s1_bin        <= '0;
            s1_pwr        <= '0;
            s1_exp        <= '0;
            run_have      <= 1'b0;
            run_err       <= 1'b0;
            run_bin       <= '0;
            run_pwr       <= '0;
            run_exp       <= '0;
            fin           <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.peak_bin  <= '0;
            bus.peak_pwr  <= '0;
            bus.peak_exp  <= '0;
            bus.frame_err <= 1'b0;
        end else begin
            s1_v <= counted;
            if (counted) begin
                s1_first <= bus.in_sop;
                s1_last  <= last;
                s1_bad   <= (bus.in_error != 2'd0) || bad_end;
                s1_cand  <= cand;
                s1_bin   <= bin;
                s1_pwr   <= pwr;
                s1_exp   <= bus.in_exp;
            end

            fin <= 1'b0;
            if (s1_v) begin
                run_have <= base_have || take;
                run_err  <= base_err || s1_bad;
                run_exp  <= s1_exp;
                fin      <= s1_last;
                if (take) begin
                    run_bin <= s1_bin;
                    run_pwr <= s1_pwr;
                end else if (s1_first) begin
                    run_bin <= '0;
                    run_pwr <= '0;
                end
            end

            if (fin) begin
                bus.out_valid <= 1'b1;
                bus.peak_bin  <= run_bin;
                bus.peak_pwr  <= run_pwr;
                bus.peak_exp  <= run_exp;
                bus.frame_err <= run_err;
            end else if (consume) begin
                bus.out_valid <= 1'b0;
            end

            unique case (state)
                IDLE, COLLECT: begin
                    bus.in_ready <= 1'b1;
                    if (counted) begin
                        if (last) begin
                            state        <= REPORT;
                            cnt          <= '0;
                            bus.in_ready <= 1'b0;
                        end else begin
                            state <= COLLECT;
                            cnt   <= bin + BW'(1);
                        end
                    end
                end
                REPORT: begin
                    if (consume) begin
                        state        <= IDLE;
                        bus.in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
